// File: rtl/pmc_shift_sequencer.sv
// pmc_shift_sequencer: generates the shA/clkSh waveform that moves one
// SHIFT_LEN-bit word through the pixel-matrix shift path, then pulses done.
// Optional acquisition gate phase before the shift: define PMC_SEQ_GATE_EN.
module pmc_shift_sequencer #(
   parameter  int SHIFT_LEN = 16,
   parameter  int DIV_W     = 8,
   localparam int CNT_W     = $clog2(SHIFT_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [3:0]       cfg_setup,
`ifdef PMC_SEQ_GATE_EN
   input  logic [15:0]      cfg_gate,
   output logic             gate,
`endif
   output logic             busy,
   output logic             done,
   output logic             shA,
   output logic             clkSh,
   output logic [CNT_W-1:0] bit_cnt
);

   // Phase counter must hold the longest latched phase length.
`ifdef PMC_SEQ_GATE_EN
   localparam int PW = (DIV_W > 16) ? DIV_W : 16;
`else
   localparam int PW = (DIV_W > 4) ? DIV_W : 4;
`endif

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
`ifdef PMC_SEQ_GATE_EN
      ST_GATE  = 3'd1,
`endif
      ST_SETUP = 3'd2,
      ST_SHIFT = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [PW-1:0]    cnt_r, cnt_nxt_s;
   logic [PW-1:0]    div_r, setup_r;
`ifdef PMC_SEQ_GATE_EN
   logic [PW-1:0]    gate_len_r;
   logic             gate_r;
`endif
   logic             clk_sh_r, clk_sh_nxt_s;
   logic [CNT_W-1:0] bit_cnt_r, bit_cnt_nxt_s;
   logic             latch_s;
   logic             busy_r, done_r, sha_r;

   // Next-state, phase counter, shift clock and pulse counter.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      clk_sh_nxt_s  = clk_sh_r;
      bit_cnt_nxt_s = bit_cnt_r;
      latch_s       = 1'b0;
      if ((state_r != ST_IDLE) && abort) begin
         // Abort drops everything except the pulse count reached so far.
         state_nxt_s  = ST_IDLE;
         cnt_nxt_s    = '0;
         clk_sh_nxt_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               clk_sh_nxt_s = 1'b0;
               if (start && !abort) begin
                  latch_s       = 1'b1;
                  bit_cnt_nxt_s = '0;
                  cnt_nxt_s     = '0;
`ifdef PMC_SEQ_GATE_EN
                  state_nxt_s   = ST_GATE;
`else
                  state_nxt_s   = ST_SETUP;
`endif
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
`ifdef PMC_SEQ_GATE_EN
            ST_GATE: begin
               if (cnt_r == gate_len_r) begin
                  cnt_nxt_s   = '0;
                  state_nxt_s = ST_SETUP;
               end else begin
                  cnt_nxt_s = cnt_r + PW'(1);
               end
            end
`endif
            ST_SETUP: begin
               if (cnt_r == setup_r) begin
                  cnt_nxt_s    = '0;
                  clk_sh_nxt_s = 1'b1;
                  state_nxt_s  = ST_SHIFT;
               end else begin
                  cnt_nxt_s = cnt_r + PW'(1);
               end
            end
            ST_SHIFT: begin
               if (cnt_r == div_r) begin
                  cnt_nxt_s = '0;
                  if (clk_sh_r) begin
                     // Falling edge completes a pulse.
                     clk_sh_nxt_s  = 1'b0;
                     bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
                  end else if (bit_cnt_r == CNT_W'(SHIFT_LEN)) begin
                     state_nxt_s = ST_HOLD;
                  end else begin
                     clk_sh_nxt_s = 1'b1;
                  end
               end else begin
                  cnt_nxt_s = cnt_r + PW'(1);
               end
            end
            ST_HOLD: begin
               if (cnt_r == div_r) begin
                  cnt_nxt_s   = '0;
                  state_nxt_s = ST_DONE;
               end else begin
                  cnt_nxt_s = cnt_r + PW'(1);
               end
            end
            ST_DONE: begin
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s  = ST_IDLE;
               cnt_nxt_s    = '0;
               clk_sh_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // State, counters and outputs, all decoded from the next state so every output is a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         clk_sh_r  <= 1'b0;
         bit_cnt_r <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         sha_r     <= 1'b0;
`ifdef PMC_SEQ_GATE_EN
         gate_r    <= 1'b0;
`endif
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         clk_sh_r  <= clk_sh_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         busy_r    <= (state_nxt_s != ST_IDLE);
         done_r    <= (state_nxt_s == ST_DONE);
         sha_r     <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_SHIFT) ||
                      (state_nxt_s == ST_HOLD);
`ifdef PMC_SEQ_GATE_EN
         gate_r    <= (state_nxt_s == ST_GATE);
`endif
      end
   end

   // Configuration snapshot taken when a start is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_r      <= '0;
         setup_r    <= '0;
`ifdef PMC_SEQ_GATE_EN
         gate_len_r <= '0;
`endif
      end else if (latch_s) begin
         div_r      <= PW'(cfg_div);
         setup_r    <= PW'(cfg_setup);
`ifdef PMC_SEQ_GATE_EN
         gate_len_r <= PW'(cfg_gate);
`endif
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign shA     = sha_r;
   assign clkSh   = clk_sh_r;
   assign bit_cnt = bit_cnt_r;
`ifdef PMC_SEQ_GATE_EN
   assign gate    = gate_r;
`endif

endmodule

// File: tb/tb_pmc_shift_sequencer.sv
// Self-checking bench for pmc_shift_sequencer: a timeline model derived from
// the phase lengths is compared every cycle, plus hand-computed checkpoints.
module tb_pmc_shift_sequencer;
   localparam int L  = 16;
   localparam int DW = 8;
   localparam int CW = $clog2(L + 1);

   logic          clk = 1'b0;
   logic          rst, start, abort;
   logic [DW-1:0] cfg_div;
   logic [3:0]    cfg_setup;
   logic          busy, done, shA, clkSh;
   logic [CW-1:0] bit_cnt;
   logic          gate_v;
`ifdef PMC_SEQ_GATE_EN
   logic [15:0]   cfg_gate;
   logic          gate;
   assign gate_v = gate;
`else
   assign gate_v = 1'b0;
`endif

   pmc_shift_sequencer #(.SHIFT_LEN(L), .DIV_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_div(cfg_div), .cfg_setup(cfg_setup),
`ifdef PMC_SEQ_GATE_EN
      .cfg_gate(cfg_gate), .gate(gate),
`endif
      .busy(busy), .done(done), .shA(shA), .clkSh(clkSh), .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---- timeline model: offset t within a run maps to phase by plain arithmetic
   function automatic logic [4:0] exp_flags(int t, int s, int d, int g); // {busy,done,shA,clkSh,gate}
      int h, u, k;
      h = d + 1;
      if (t <= g) return 5'b10001;
      u = t - g;
      if (u <= s + 1) return 5'b10100;
      k = u - s - 2;
      if (k < 2 * L * h) return ((k % (2 * h)) < h) ? 5'b10110 : 5'b10100;
      k = k - 2 * L * h;
      if (k < h) return 5'b10100;
      return 5'b11000;
   endfunction

   function automatic int exp_bits(int t, int s, int d, int g);
      int h, k;
      h = d + 1;
      if (t <= g + s + 1) return 0;
      k = t - g - s - 2;
      if (k < 2 * L * h) return (k + h) / (2 * h);
      return L;
   endfunction

   function automatic int run_len(int s, int d, int g);
      return g + (s + 1) + 2 * L * (d + 1) + (d + 1) + 1;
   endfunction

   bit m_run = 1'b0;
   int m_t = 0, m_s = 0, m_d = 0, m_g = 0, m_bc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_run <= 1'b0;
         m_bc  <= 0;
      end else if (m_run) begin
         if (abort || (m_t == run_len(m_s, m_d, m_g))) begin
            m_run <= 1'b0;
            m_bc  <= exp_bits(m_t, m_s, m_d, m_g);
         end else begin
            m_t <= m_t + 1;
         end
      end else if (start && !abort) begin
         m_run <= 1'b1;
         m_t   <= 1;
         m_s   <= int'(cfg_setup);
         m_d   <= int'(cfg_div);
`ifdef PMC_SEQ_GATE_EN
         m_g   <= int'(cfg_gate) + 1;
`else
         m_g   <= 0;
`endif
         m_bc  <= 0;
      end
   end

   // ---- monitor: per-cycle compare plus event logs for the checkpoints
   int busy_cyc = 0;
   int gate_cyc = 0;
   int done_q[$];
   int rise_q[$];
   int sha_q[$];
   logic clk_prev = 1'b0, sha_prev = 1'b0;

   always @(negedge clk) begin
      logic [4:0] e;
      int         eb;
      if (chk_en) begin
         e  = m_run ? exp_flags(m_t, m_s, m_d, m_g) : 5'b00000;
         eb = m_run ? exp_bits(m_t, m_s, m_d, m_g) : m_bc;
         check("flags{busy,done,shA,clkSh,gate}", {busy, done, shA, clkSh, gate_v}, e);
         check("bit_cnt", bit_cnt, eb);
         if (busy) busy_cyc++;
         if (gate_v) gate_cyc++;
         if (done) done_q.push_back(cyc);
         if (clkSh && !clk_prev) rise_q.push_back(cyc);
         if (shA && !sha_prev) sha_q.push_back(cyc);
         clk_prev = clkSh;
         sha_prev = shA;
      end
   end

   // ---- stimulus helpers: inputs change 2 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_start(output int t0);
      start = 1'b1;
      t0 = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int limit, input string name);
      int n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      check(name, busy, 0);
   endtask

   int t0, b_busy, b_done, b_rise, b_sha, b_gate;

   task automatic snap();
      b_busy = busy_cyc;
      b_done = done_q.size();
      b_rise = rise_q.size();
      b_sha  = sha_q.size();
      b_gate = gate_cyc;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_div = '0; cfg_setup = '0;
`ifdef PMC_SEQ_GATE_EN
      cfg_gate = 16'd0;
`endif
      repeat (3) tick();
      rst = 1'b0;
      chk_en = 1'b1;
      tick();
      check("reset_busy", busy, 0);
      check("reset_shA", shA, 0);
      check("reset_bit_cnt", bit_cnt, 0);

      // Basic run D=0 S=0
      snap();
      do_start(t0);
      wait_idle(200, "t1_timeout");
      check("t1_busy_cycles", busy_cyc - b_busy, 35 + (m_g));
      check("t1_pulses", rise_q.size() - b_rise, 16);
      check("t1_bit_cnt_final", bit_cnt, 16);
      if (done_q.size() == b_done + 1) check("t1_done_offset", done_q[b_done] - t0, 35 + m_g);
      else check("t1_done_count", done_q.size() - b_done, 1);
      if (sha_q.size() > b_sha) check("t1_shA_rise_offset", sha_q[b_sha] - t0, 1 + m_g);
      if (rise_q.size() > b_rise) check("t1_first_clk_offset", rise_q[b_rise] - t0, 2 + m_g);
`ifdef PMC_SEQ_GATE_EN
      check("t1_gate_cycles", gate_cyc - b_gate, 1);
`endif
      tick();

      // D=2 S=3, config changed mid-run must not matter
      cfg_div = 8'd2; cfg_setup = 4'd3;
      snap();
      do_start(t0);
      cfg_div = 8'd0; cfg_setup = 4'd0;
      wait_idle(400, "t2_timeout");
      check("t2_busy_cycles", busy_cyc - b_busy, 104 + m_g);
      check("t2_pulses", rise_q.size() - b_rise, 16);
      if (rise_q.size() > b_rise && sha_q.size() > b_sha)
         check("t2_setup_gap", rise_q[b_rise] - sha_q[b_sha], 4);
      tick();

      // Abort at the 5th clkSh high cycle (offset 10 without gate)
      snap();
      do_start(t0);
      while (cyc < t0 + 10 + m_g) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_shA", shA, 0);
      check("abort_clkSh", clkSh, 0);
      check("abort_bit_cnt", bit_cnt, 4);
      repeat (3) tick();
      check("abort_no_done", done_q.size() - b_done, 0);

      // start with abort in IDLE: dropped
      snap();
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      repeat (3) tick();
      check("start_abort_busy", busy_cyc - b_busy, 0);

      // start during SHIFT ignored
      snap();
      do_start(t0);
      while (cyc < t0 + 10 + m_g) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(200, "t5_timeout");
      check("shift_start_pulses", rise_q.size() - b_rise, 16);
      check("shift_start_dones", done_q.size() - b_done, 1);
      repeat (3) tick();
      check("shift_start_no_rerun", busy, 0);

      // rst mid-run
      do_start(t0);
      while (cyc < t0 + 10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_shA", shA, 0);
      check("rst_bit_cnt", bit_cnt, 0);
      tick();

      // Back-to-back with start held high
      snap();
      start = 1'b1;
      t0 = cyc;
      for (int n = 0; n < 400 && done_q.size() < b_done + 3; n++) tick();
      start = 1'b0;
      wait_idle(200, "b2b_timeout");
      check("b2b_done_count", done_q.size() - b_done, 3);
      if (done_q.size() >= b_done + 3) begin
         check("b2b_first_done", done_q[b_done] - t0, 35 + m_g);
         check("b2b_period_1", done_q[b_done+1] - done_q[b_done], 36 + m_g);
         check("b2b_period_2", done_q[b_done+2] - done_q[b_done+1], 36 + m_g);
      end
      tick();

      // Maximum divider
      cfg_div = 8'hFF; cfg_setup = 4'd0;
      snap();
      do_start(t0);
      wait_idle(10000, "maxdiv_timeout");
      check("maxdiv_busy_cycles", busy_cyc - b_busy, 8450 + m_g);
      check("maxdiv_pulses", rise_q.size() - b_rise, 16);
      tick();

`ifdef PMC_SEQ_GATE_EN
      // Gate phase, cfg_gate=9
      cfg_div = 8'd0; cfg_setup = 4'd0; cfg_gate = 16'd9;
      snap();
      do_start(t0);
      wait_idle(300, "gate_timeout");
      check("gate_cycles", gate_cyc - b_gate, 10);
      if (sha_q.size() > b_sha) check("gate_shA_rise", sha_q[b_sha] - t0, 11);
      if (done_q.size() > b_done) check("gate_done_offset", done_q[b_done] - t0, 45);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
